// File: rtl/viterbi_regx_decoder.sv
// Soft-decision Viterbi decoder, one symbol per clock: branch metric, add-compare-select
// and register-exchange survivors over tail-terminated frames with valid/ready on both sides.
module viterbi_regx_decoder #(
    parameter int                  K        = 4,
    parameter int                  RATE_N   = 3,
    parameter int                  SOFT_W   = 4,
    parameter logic [RATE_N*K-1:0] G        = 12'hFDB,
    parameter int                  PM_W     = 10,
    parameter int                  TB_DEPTH = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [RATE_N*SOFT_W-1:0] in_sym,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_bit,
    output logic                     out_last,
    output logic [1:0]               o_dbg_state
);

    localparam int S_W   = K - 1;
    localparam int NS    = 1 << S_W;
    localparam int CNT_W = $clog2(TB_DEPTH + 1);
    localparam int IDX_W = $clog2(TB_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TB_DEPTH);
    localparam logic [CNT_W-1:0] R_MAX   = CNT_W'(TB_DEPTH - 1);
    localparam logic [PM_W-1:0]  PM_INIT = {2'b01, {(PM_W-2){1'b0}}};

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    // Handshakes: a beat transfers on the rising edge where valid && ready; the producer
    // holds valid and payload stable until that edge and never withdraws valid early.

    state_t                r_state;
    state_t                w_state_nxt;
    logic [PM_W-1:0]       r_pm [NS];
    // The oldest survivor bit is only ever read combinationally, so it is never stored.
    logic [TB_DEPTH-2:0]   r_sv [NS];
    logic [CNT_W-1:0]      r_cnt;
    logic [TB_DEPTH-2:0]   r_fl_sv;
    logic [CNT_W-1:0]      r_fl_rem;
    logic                  r_out_valid;
    logic                  r_out_bit;
    logic                  r_out_last;

    logic [PM_W-1:0]       w_pm_acs [NS];
    logic [TB_DEPTH-1:0]   w_sv_new [NS];
    logic [PM_W-1:0]       w_pm_min;
    logic [S_W-1:0]        w_best;
    logic                  w_dec;
    logic                  w_accept;
    logic                  w_out_free;
    logic [CNT_W-1:0]      w_cnt_inc;
    logic                  w_run_emit;
    logic                  w_fl_emit;
    logic [IDX_W-1:0]      w_fl_idx;

    function automatic logic [PM_W-1:0] branch_metric(
        input logic [K-1:0]               e,
        input logic [RATE_N*SOFT_W-1:0]   sym
    );
        logic [PM_W-1:0]   acc;
        logic [SOFT_W-1:0] y;
        acc = '0;
        for (int i = 0; i < RATE_N; i++) begin
            y = sym[i*SOFT_W +: SOFT_W];
            if (^(G[i*K +: K] & e)) y = ~y;
            acc = acc + {{(PM_W-SOFT_W){1'b0}}, y};
        end
        return acc;
    endfunction

    for (genvar gs = 0; gs < NS; gs++) begin : g_acs
        localparam logic [S_W-1:0] NS_V = S_W'(gs);
        localparam logic [S_W-1:0] P0   = {1'b0, NS_V[S_W-1:1]};
        localparam logic [S_W-1:0] P1   = {1'b1, NS_V[S_W-1:1]};
        logic [PM_W-1:0] w_c0;
        logic [PM_W-1:0] w_c1;
        logic            w_sel;
        assign w_c0  = r_pm[P0] + branch_metric({P0, NS_V[0]}, in_sym);
        assign w_c1  = r_pm[P1] + branch_metric({P1, NS_V[0]}, in_sym);
        assign w_sel = (w_c1 < w_c0);
        assign w_pm_acs[gs] = w_sel ? w_c1 : w_c0;
        assign w_sv_new[gs] = w_sel ? {r_sv[P1], NS_V[0]} : {r_sv[P0], NS_V[0]};
    end

    always_comb begin
        w_pm_min = w_pm_acs[0];
        for (int i = 1; i < NS; i++) begin
            if (w_pm_acs[i] < w_pm_min) w_pm_min = w_pm_acs[i];
        end
        w_best = '0;
        for (int i = NS - 1; i >= 0; i--) begin
            if (w_pm_acs[i] == w_pm_min) w_best = S_W'(i);
        end
    end

    // A terminated frame ends in state 0, so the last beat decodes from that survivor.
    assign w_dec      = in_last ? w_sv_new[0][TB_DEPTH-1] : w_sv_new[w_best][TB_DEPTH-1];
    assign w_out_free = !r_out_valid || out_ready;
    assign in_ready   = (r_state == ST_RUN) && w_out_free;
    assign w_accept   = in_valid && in_ready;
    assign w_cnt_inc  = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;
    assign w_run_emit = w_accept && (w_cnt_inc == CNT_MAX);
    assign w_fl_emit  = (r_state == ST_FLUSH) && w_out_free && (r_fl_rem != '0);
    assign w_fl_idx   = IDX_W'(r_fl_rem - 1'b1);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_INIT:  w_state_nxt = ST_RUN;
            ST_RUN:   if (w_accept && in_last) w_state_nxt = ST_FLUSH;
            ST_FLUSH: if (r_out_valid && out_ready && r_out_last) w_state_nxt = ST_INIT;
            default:  w_state_nxt = ST_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_INIT;
            r_cnt       <= '0;
            r_fl_sv     <= '0;
            r_fl_rem    <= '0;
            r_out_valid <= 1'b0;
            r_out_bit   <= 1'b0;
            r_out_last  <= 1'b0;
            for (int i = 0; i < NS; i++) begin
                r_pm[i] <= '0;
                r_sv[i] <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_INIT) begin
                r_cnt <= '0;
                for (int i = 0; i < NS; i++) begin
                    r_pm[i] <= (i == 0) ? '0 : PM_INIT;
                    r_sv[i] <= '0;
                end
            end else if (w_accept) begin
                r_cnt <= w_cnt_inc;
                for (int i = 0; i < NS; i++) begin
                    r_pm[i] <= w_pm_acs[i] - w_pm_min;
                    r_sv[i] <= w_sv_new[i][TB_DEPTH-2:0];
                end
                if (in_last) begin
                    r_fl_sv  <= w_sv_new[0][TB_DEPTH-2:0];
                    r_fl_rem <= (w_cnt_inc == CNT_MAX) ? R_MAX : w_cnt_inc;
                end
            end

            if (w_run_emit) begin
                r_out_valid <= 1'b1;
                r_out_bit   <= w_dec;
                r_out_last  <= 1'b0;
            end else if (w_fl_emit) begin
                r_out_valid <= 1'b1;
                r_out_bit   <= r_fl_sv[w_fl_idx];
                r_out_last  <= (r_fl_rem == CNT_W'(1));
                r_fl_rem    <= r_fl_rem - 1'b1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end
        end
    end

    assign out_valid   = r_out_valid;
    assign out_bit     = r_out_bit;
    assign out_last    = r_out_last;
    assign o_dbg_state = r_state;

endmodule
